// File: rtl/oc_issue_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// oc_issue_arbiter_pkg
// Shared definitions for the issue arbiter, the writeback mux and the operand
// collectors: default latency/limit parameters and the writeback tracking
// entry carried down the ALU writeback shift register.
// ---------------------------------------------------------------------------
package oc_issue_arbiter_pkg;

  localparam int NUM_OC_DEF      = 4;
  localparam int ALU_LAT_DEF     = 3;
  localparam int MAX_MEM_OUT_DEF = 4;

  // Widest OC index the entry can carry (up to 16 collectors); narrower
  // configurations zero-extend into it.
  localparam int OC_IDX_MAX_W    = 4;

  typedef struct packed {
    logic                    valid;
    logic [OC_IDX_MAX_W-1:0] ocIdx;
  } wb_entry_t;

endpackage

// File: rtl/oc_issue_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Single-resource round-robin arbiter. The search starts at the registered
// pointer and ascends with wrap-around; the first requesting index wins and
// the pointer moves to the index just past the winner.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset (pointer -> 0)
//   req        in   N  eligible request vector
//   grant      out  N  one-hot-or-zero grant (combinational)
//   grantValid out  1  any grant this cycle
//   grantIdx   out  $clog2(N) index of the granted requester (0 if none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grantValid,
  output logic [$clog2(N)-1:0] grantIdx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptrReg;
  logic [IDX_W-1:0] ptrNext;

  always_comb begin
    grant      = '0;
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!grantValid && req[(int'(ptrReg) + k) % N]) begin
        grantValid = 1'b1;
        grantIdx   = IDX_W'((int'(ptrReg) + k) % N);
        grant[(int'(ptrReg) + k) % N] = 1'b1;
      end
    end
  end

  always_comb begin
    ptrNext = ptrReg;
    if (grantValid) begin
      ptrNext = (grantIdx == IDX_W'(N - 1)) ? '0 : grantIdx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptrReg <= '0;
    end else begin
      ptrReg <= ptrNext;
    end
  end

endmodule

// File: rtl/oc_issue_arbiter.sv
// ---------------------------------------------------------------------------
// oc_issue_arbiter
// Issues at most one ALU and one MEM request per cycle from the operand
// collectors, each with its own round-robin order. ALU ops that write the
// register file are held off in the cycle whose writeback slot MEM already
// owns, MEM issue is throttled by an in-flight counter, and a shift register
// tracks pending ALU writebacks for the writeback mux.
//
// Ports:
//   clk                          in   clock
//   rst                          in   asynchronous active-low reset
//   ALU_Req_OC_Sched             in   NUM_OC per-OC ready ALU instruction
//   ALU_RegWrite_OC_Sched        in   NUM_OC per-OC ALU op writes the RF
//   MEM_Req_OC_Sched             in   NUM_OC per-OC ready load/store
//   RegWrite_LastStage_MEM_Sched in   1  MEM writes the RF ALU_LAT cycles on
//   MEM_Done_Mem_Sched           in   1  one MEM request retired (pulse)
//   ALU_Grt_Sched_OC             out  NUM_OC ALU grant (one-hot or zero)
//   MEM_Grt_Sched_OC             out  NUM_OC MEM grant (one-hot or zero)
//   ALU_WB_Valid_Sched           out  1  ALU writes the RF this cycle
//   ALU_WB_OC_Sched              out  $clog2(NUM_OC) OC of that write
//   WB_Conflict_Err              out  1  sticky ALU/MEM write collision
// ---------------------------------------------------------------------------
module oc_issue_arbiter
  import oc_issue_arbiter_pkg::*;
#(
  parameter int NUM_OC      = NUM_OC_DEF,
  parameter int ALU_LAT     = ALU_LAT_DEF,
  parameter int MAX_MEM_OUT = MAX_MEM_OUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_OC-1:0]         ALU_Req_OC_Sched,
  input  logic [NUM_OC-1:0]         ALU_RegWrite_OC_Sched,
  input  logic [NUM_OC-1:0]         MEM_Req_OC_Sched,
  input  logic                      RegWrite_LastStage_MEM_Sched,
  input  logic                      MEM_Done_Mem_Sched,
  output logic [NUM_OC-1:0]         ALU_Grt_Sched_OC,
  output logic [NUM_OC-1:0]         MEM_Grt_Sched_OC,
  output logic                      ALU_WB_Valid_Sched,
  output logic [$clog2(NUM_OC)-1:0] ALU_WB_OC_Sched,
  output logic                      WB_Conflict_Err
);

  localparam int IDX_W = $clog2(NUM_OC);
  localparam int CNT_W = $clog2(MAX_MEM_OUT + 1);

  logic [NUM_OC-1:0] aluElig;
  logic [NUM_OC-1:0] memElig;
  logic              aluGrantValid;
  logic              memGrantValid;
  logic [IDX_W-1:0]  aluGrantIdx;
  logic [IDX_W-1:0]  memGrantIdx;

  logic [CNT_W-1:0]  memCntReg;
  logic [CNT_W-1:0]  memCntNext;
  logic              memDoneEff;

  wb_entry_t         wbIn;
  wb_entry_t         wbPipe    [ALU_LAT];
  logic              memWrPipe [ALU_LAT];
  wb_entry_t         wbHead;
  logic              conflictRegNext;

  // A MEM writeback flag now means MEM owns the RF port ALU_LAT cycles later,
  // which is exactly where an ALU op granted now would write.
  assign aluElig = ALU_Req_OC_Sched &
                   ~(ALU_RegWrite_OC_Sched & {NUM_OC{RegWrite_LastStage_MEM_Sched}});
  assign memElig = (memCntReg < CNT_W'(MAX_MEM_OUT)) ? MEM_Req_OC_Sched : '0;

  rr_arbiter #(.N(NUM_OC)) uAluArb (
    .clk        (clk),
    .rst        (rst),
    .req        (aluElig),
    .grant      (ALU_Grt_Sched_OC),
    .grantValid (aluGrantValid),
    .grantIdx   (aluGrantIdx)
  );

  rr_arbiter #(.N(NUM_OC)) uMemArb (
    .clk        (clk),
    .rst        (rst),
    .req        (memElig),
    .grant      (MEM_Grt_Sched_OC),
    .grantValid (memGrantValid),
    .grantIdx   (memGrantIdx)
  );

  // Done with nothing outstanding is dropped so the counter cannot wrap.
  assign memDoneEff = MEM_Done_Mem_Sched && (memCntReg != '0);

  always_comb begin
    memCntNext = memCntReg;
    if (memGrantValid && !memDoneEff) begin
      memCntNext = memCntReg + CNT_W'(1);
    end else if (memDoneEff && !memGrantValid) begin
      memCntNext = memCntReg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memCntReg <= '0;
    end else begin
      memCntReg <= memCntNext;
    end
  end

  always_comb begin
    wbIn       = '0;
    wbIn.valid = aluGrantValid && ALU_RegWrite_OC_Sched[aluGrantIdx];
    wbIn.ocIdx = OC_IDX_MAX_W'(aluGrantIdx);
  end

  // Stage 0 is visible the cycle after the grant, so stage ALU_LAT-1 lines up
  // with grant cycle + ALU_LAT.
  genvar gi;
  for (gi = 0; gi < ALU_LAT; gi++) begin : gStage
    wb_entry_t stageIn;
    logic      memIn;
    if (gi == 0) begin : gFirst
      assign stageIn = wbIn;
      assign memIn   = RegWrite_LastStage_MEM_Sched;
    end else begin : gRest
      assign stageIn = wbPipe[gi-1];
      assign memIn   = memWrPipe[gi-1];
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wbPipe[gi]    <= '0;
        memWrPipe[gi] <= 1'b0;
      end else begin
        wbPipe[gi]    <= stageIn;
        memWrPipe[gi] <= memIn;
      end
    end
  end

  assign wbHead             = wbPipe[ALU_LAT-1];
  assign ALU_WB_Valid_Sched = wbHead.valid;
  assign ALU_WB_OC_Sched    = wbHead.valid ? wbHead.ocIdx[IDX_W-1:0] : '0;

  assign conflictRegNext = WB_Conflict_Err | (wbHead.valid & memWrPipe[ALU_LAT-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_Conflict_Err <= 1'b0;
    end else begin
      WB_Conflict_Err <= conflictRegNext;
    end
  end

endmodule

// File: tb/tb_oc_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oc_issue_arbiter
// Directed bench for oc_issue_arbiter (NUM_OC=4, ALU_LAT=3, MAX_MEM_OUT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_oc_issue_arbiter;

  localparam int NUM_OC      = 4;
  localparam int ALU_LAT     = 3;
  localparam int MAX_MEM_OUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] aluReq = '0;
  logic [3:0] aluRw  = '0;
  logic [3:0] memReq = '0;
  logic       memWbFlag = 1'b0;
  logic       memDone   = 1'b0;
  logic [3:0] aluGrt;
  logic [3:0] memGrt;
  logic       wbValid;
  logic [1:0] wbOc;
  logic       conflictErr;

  int checkCnt = 0;
  int passCnt  = 0;
  int violCnt  = 0;

  always #5 clk = ~clk;

  oc_issue_arbiter #(
    .NUM_OC      (NUM_OC),
    .ALU_LAT     (ALU_LAT),
    .MAX_MEM_OUT (MAX_MEM_OUT)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .ALU_Req_OC_Sched             (aluReq),
    .ALU_RegWrite_OC_Sched        (aluRw),
    .MEM_Req_OC_Sched             (memReq),
    .RegWrite_LastStage_MEM_Sched (memWbFlag),
    .MEM_Done_Mem_Sched           (memDone),
    .ALU_Grt_Sched_OC             (aluGrt),
    .MEM_Grt_Sched_OC             (memGrt),
    .ALU_WB_Valid_Sched           (wbValid),
    .ALU_WB_OC_Sched              (wbOc),
    .WB_Conflict_Err              (conflictErr)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      passCnt++;
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  // Check both grant vectors in the current cycle, then move to the next.
  task automatic expGrants(input string tag, input logic [3:0] a, input logic [3:0] m);
    @(negedge clk);
    checkVal({tag, "_alu"}, 32'(aluGrt), 32'(a));
    checkVal({tag, "_mem"}, 32'(memGrt), 32'(m));
    nextCyc();
  endtask

  task automatic expWb(input string tag, input logic v, input logic [1:0] oc);
    @(negedge clk);
    checkVal({tag, "_valid"}, 32'(wbValid), 32'(v));
    checkVal({tag, "_oc"}, 32'(wbOc), 32'(oc));
    nextCyc();
  endtask

  initial begin
    // Grants are combinational even while reset is held; pointers are 0.
    aluReq = 4'b0100;
    @(negedge clk);
    checkVal("rst_alu_grant", 32'(aluGrt), 32'h4);
    checkVal("rst_wb_valid", 32'(wbValid), 32'h0);
    checkVal("rst_wb_oc", 32'(wbOc), 32'h0);
    checkVal("rst_conflict", 32'(conflictErr), 32'h0);
    nextCyc();
    aluReq = '0;
    rst = 1'b1;
    nextCyc();

    // Round-robin fairness with all four ALU requests held.
    aluReq = 4'b1111;
    expGrants("rr0", 4'b0001, 4'b0000);
    expGrants("rr1", 4'b0010, 4'b0000);
    expGrants("rr2", 4'b0100, 4'b0000);
    expGrants("rr3", 4'b1000, 4'b0000);
    expGrants("rr4", 4'b0001, 4'b0000);

    // Bring alu_ptr back to 0, then mask OC0's writing op under a MEM slot.
    aluReq = 4'b1000;
    expGrants("ptr_to0", 4'b1000, 4'b0000);
    aluReq = 4'b0011; aluRw = 4'b0001; memWbFlag = 1'b1;
    expGrants("mask", 4'b0010, 4'b0000);
    aluReq = 4'b0001; aluRw = 4'b0001; memWbFlag = 1'b0;
    expGrants("unmask", 4'b0001, 4'b0000);
    aluReq = '0; aluRw = '0;
    expWb("wb0_t1", 1'b0, 2'd0);
    expWb("wb0_t2", 1'b0, 2'd0);
    expWb("wb0_t3", 1'b1, 2'd0);
    expWb("wb0_t4", 1'b0, 2'd0);

    // Writeback tracking for OC2 (alu_ptr is 1 here).
    aluReq = 4'b0100; aluRw = 4'b0100;
    expGrants("wb2_grant", 4'b0100, 4'b0000);
    aluReq = '0; aluRw = '0;
    expWb("wb2_t1", 1'b0, 2'd0);
    expWb("wb2_t2", 1'b0, 2'd0);
    expWb("wb2_t3", 1'b1, 2'd2);
    expWb("wb2_t4", 1'b0, 2'd0);

    // MEM throttling at four outstanding.
    memReq = 4'b1111;
    expGrants("mem0", 4'b0000, 4'b0001);
    expGrants("mem1", 4'b0000, 4'b0010);
    expGrants("mem2", 4'b0000, 4'b0100);
    expGrants("mem3", 4'b0000, 4'b1000);
    expGrants("mem_full", 4'b0000, 4'b0000);
    memDone = 1'b1;
    expGrants("mem_done_same", 4'b0000, 4'b0000);
    memDone = 1'b0;
    expGrants("mem_after_done", 4'b0000, 4'b0001);
    expGrants("mem_full2", 4'b0000, 4'b0000);
    memDone = 1'b1;
    expGrants("mem_done2", 4'b0000, 4'b0000);
    expGrants("mem_grant_done", 4'b0000, 4'b0010);
    memDone = 1'b0;
    expGrants("mem_held_cnt", 4'b0000, 4'b0100);
    expGrants("mem_full3", 4'b0000, 4'b0000);

    // Drain, plus one extra Done at zero that must be ignored.
    memReq = '0; memDone = 1'b1;
    repeat (5) nextCyc();
    memDone = 1'b0; memReq = 4'b1111;
    expGrants("mem_nouf0", 4'b0000, 4'b1000);
    expGrants("mem_nouf1", 4'b0000, 4'b0001);
    expGrants("mem_nouf2", 4'b0000, 4'b0010);
    expGrants("mem_nouf3", 4'b0000, 4'b0100);
    expGrants("mem_nouf4", 4'b0000, 4'b0000);
    memReq = '0; memDone = 1'b1;
    repeat (4) nextCyc();
    memDone = 1'b0;

    // Simultaneous ALU and MEM grants to one OC; both pointers advance.
    aluReq = 4'b1000; memReq = 4'b1000;
    expGrants("sim_ptr0", 4'b1000, 4'b1000);
    aluReq = 4'b0100; memReq = 4'b0100;
    expGrants("sim_oc2", 4'b0100, 4'b0100);
    aluReq = 4'b1111; memReq = 4'b1111;
    expGrants("sim_ptr3", 4'b1000, 4'b1000);
    aluReq = '0; memReq = '0;

    // Reset mid-flight discards the pending writeback and clears state.
    aluReq = 4'b0001; aluRw = 4'b0001;
    expGrants("rf_grant", 4'b0001, 4'b0000);
    aluReq = '0; aluRw = '0; rst = 1'b0;
    expWb("rf_t1", 1'b0, 2'd0);
    rst = 1'b1;
    expWb("rf_t2", 1'b0, 2'd0);
    aluReq = 4'b1111; memReq = 4'b1111;
    @(negedge clk);
    checkVal("rf_t3_valid", 32'(wbValid), 32'h0);
    checkVal("rf_t3_alu", 32'(aluGrt), 32'h1);
    checkVal("rf_t3_mem", 32'(memGrt), 32'h1);
    nextCyc();
    expGrants("rf_cnt1", 4'b0010, 4'b0010);
    expGrants("rf_cnt2", 4'b0100, 4'b0100);
    expGrants("rf_cnt3", 4'b1000, 4'b1000);
    aluReq = '0;
    expGrants("rf_cnt4", 4'b0000, 4'b0000);

    // Random traffic: grants must stay one-hot-or-zero and within requests,
    // and the writeback masking must keep the RF port conflict-free.
    for (int c = 0; c < 3000; c++) begin
      aluReq    = 4'($urandom);
      aluRw     = 4'($urandom);
      memReq    = 4'($urandom);
      memWbFlag = 1'($urandom_range(0, 1));
      memDone   = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if ($countones(aluGrt) > 1 || $countones(memGrt) > 1 ||
          (aluGrt & ~aluReq) != 4'b0 || (memGrt & ~memReq) != 4'b0) begin
        violCnt++;
      end
      nextCyc();
    end
    aluReq = '0; aluRw = '0; memReq = '0; memWbFlag = 1'b0; memDone = 1'b0;
    repeat (ALU_LAT + 2) nextCyc();
    checkVal("rand_grant_shape", 32'(violCnt), 32'h0);
    checkVal("rand_conflict", 32'(conflictErr), 32'h0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
